// File: rtl/eh2_lsu_amo_seq.sv
// Multi-cycle A-extension sequencer: read -> modify -> write against a memory port,
// with per-thread LR/SC reservation tracking at a configurable granule.
module eh2_lsu_amo_seq #(
  parameter int unsigned XLEN          = 32,
  parameter int unsigned NUM_THREADS   = 2,
  parameter int unsigned RSV_GRAN_LOG2 = 2,
  localparam int unsigned TW = (NUM_THREADS > 1) ? $clog2(NUM_THREADS) : 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   req_valid,
  output logic                   req_ready,
  input  logic [TW-1:0]          req_tid,
  input  logic [4:0]             req_op,
  input  logic                   req_dw,
  input  logic [31:0]            req_addr,
  input  logic [XLEN-1:0]        req_wdata,
  output logic                   mem_rd_valid,
  input  logic                   mem_rd_ready,
  input  logic                   mem_rdata_vld,
  input  logic [XLEN-1:0]        mem_rdata,
  output logic                   mem_wr_valid,
  input  logic                   mem_wr_ready,
  output logic [31:0]            mem_addr,
  output logic                   mem_dw,
  output logic [XLEN-1:0]        mem_wdata,
  output logic                   rsp_valid,
  output logic [TW-1:0]          rsp_tid,
  output logic [XLEN-1:0]        rsp_data,
  output logic                   rsp_err,
  input  logic                   snoop_valid,
  input  logic [31:0]            snoop_addr,
  input  logic [NUM_THREADS-1:0] rsv_clear
);

  localparam int unsigned GW = 32 - RSV_GRAN_LOG2;

  localparam logic [4:0] OpAdd  = 5'd0;
  localparam logic [4:0] OpSwap = 5'd1;
  localparam logic [4:0] OpLr   = 5'd2;
  localparam logic [4:0] OpSc   = 5'd3;
  localparam logic [4:0] OpXor  = 5'd4;
  localparam logic [4:0] OpOr   = 5'd8;
  localparam logic [4:0] OpAnd  = 5'd12;
  localparam logic [4:0] OpMin  = 5'd16;
  localparam logic [4:0] OpMax  = 5'd20;
  localparam logic [4:0] OpMinu = 5'd24;
  localparam logic [4:0] OpMaxu = 5'd28;

  typedef enum logic [2:0] {StIdle, StRd, StRwait, StWr, StResp} state_e;

  state_e            state_q, state_d;
  logic [TW-1:0]     tid_q, tid_d;
  logic [4:0]        op_q, op_d;
  logic              dw_q, dw_d;
  logic [31:0]       addr_q, addr_d;
  logic [XLEN-1:0]   wdata_q, wdata_d;
  logic [XLEN-1:0]   wr_data_q, wr_data_d;
  logic [XLEN-1:0]   rsp_data_q, rsp_data_d;
  logic              rsp_err_q, rsp_err_d;

  logic [NUM_THREADS-1:0] rsv_vld_q, rsv_vld_d;
  logic [GW-1:0]          rsv_gran_q [NUM_THREADS];
  logic [GW-1:0]          rsv_gran_d [NUM_THREADS];

  logic                   op_legal, misaligned, req_err, sc_ok, wr_fire;
  logic [GW-1:0]          req_gran, cur_gran, snoop_gran;
  logic [NUM_THREADS-1:0] kill_q;
  logic                   unused_bits;

  assign req_gran    = req_addr[31:RSV_GRAN_LOG2];
  assign cur_gran    = addr_q[31:RSV_GRAN_LOG2];
  assign snoop_gran  = snoop_addr[31:RSV_GRAN_LOG2];
  assign wr_fire     = (state_q == StWr) && mem_wr_ready;
  assign unused_bits = ^snoop_addr[RSV_GRAN_LOG2-1:0];

  always_comb begin
    op_legal = 1'b0;
    case (req_op)
      OpAdd, OpSwap, OpLr, OpSc, OpXor, OpOr, OpAnd,
      OpMin, OpMax, OpMinu, OpMaxu: op_legal = 1'b1;
      default:                      op_legal = 1'b0;
    endcase
  end

  assign misaligned = req_dw ? (req_addr[2:0] != 3'b000) : (req_addr[1:0] != 2'b00);
  assign req_err    = misaligned || (req_dw && (XLEN < 64)) || !op_legal;

  // Kills seen against the current reservations; SC in idle must observe these.
  always_comb begin
    for (int t = 0; t < NUM_THREADS; t++) begin
      kill_q[t] = (snoop_valid && (rsv_gran_q[t] == snoop_gran)) ||
                  (wr_fire && (rsv_gran_q[t] == cur_gran));
    end
  end

  assign sc_ok = rsv_vld_q[req_tid] && !kill_q[req_tid] && !rsv_clear[req_tid] &&
                 (rsv_gran_q[req_tid] == req_gran);

  // Modify datapath: word ops work on [31:0], signed/unsigned views of both operands.
  logic [XLEN-1:0] a_u, b_u, a_s, b_s, alu_res, wr_val, old_val;
  logic            a_lt_b_s, b_lt_a_s, a_lt_b_u, b_lt_a_u;

  always_comb begin
    if (dw_q) begin
      a_u = mem_rdata;
      b_u = wdata_q;
      a_s = mem_rdata;
      b_s = wdata_q;
    end else begin
      a_u = XLEN'(mem_rdata[31:0]);
      b_u = XLEN'(wdata_q[31:0]);
      a_s = XLEN'($signed(mem_rdata[31:0]));
      b_s = XLEN'($signed(wdata_q[31:0]));
    end
    a_lt_b_s = $signed(a_s) < $signed(b_s);
    b_lt_a_s = $signed(b_s) < $signed(a_s);
    a_lt_b_u = a_u < b_u;
    b_lt_a_u = b_u < a_u;

    // Ties keep the memory value.
    case (op_q)
      OpAdd:   alu_res = a_u + b_u;
      OpSwap:  alu_res = b_u;
      OpXor:   alu_res = a_u ^ b_u;
      OpOr:    alu_res = a_u | b_u;
      OpAnd:   alu_res = a_u & b_u;
      OpMin:   alu_res = b_lt_a_s ? b_u : a_u;
      OpMax:   alu_res = a_lt_b_s ? b_u : a_u;
      OpMinu:  alu_res = b_lt_a_u ? b_u : a_u;
      OpMaxu:  alu_res = a_lt_b_u ? b_u : a_u;
      default: alu_res = a_u;
    endcase

    wr_val  = dw_q ? alu_res : XLEN'(alu_res[31:0]);
    old_val = a_s;
  end

  always_comb begin
    state_d    = state_q;
    tid_d      = tid_q;
    op_d       = op_q;
    dw_d       = dw_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    wr_data_d  = wr_data_q;
    rsp_data_d = rsp_data_q;
    rsp_err_d  = rsp_err_q;
    rsv_vld_d  = rsv_vld_q;
    rsv_gran_d = rsv_gran_q;

    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          tid_d      = req_tid;
          op_d       = req_op;
          dw_d       = req_dw;
          addr_d     = req_addr;
          wdata_d    = req_wdata;
          rsp_err_d  = 1'b0;
          rsp_data_d = '0;
          if (req_err) begin
            rsp_err_d = 1'b1;
            state_d   = StResp;
          end else if (req_op == OpSc) begin
            if (sc_ok) begin
              wr_data_d = req_dw ? req_wdata : XLEN'(req_wdata[31:0]);
              state_d   = StWr;
            end else begin
              rsp_data_d = XLEN'(1);
              state_d    = StResp;
            end
          end else begin
            state_d = StRd;
          end
        end
      end
      StRd: begin
        if (mem_rd_ready) state_d = StRwait;
      end
      StRwait: begin
        if (mem_rdata_vld) begin
          rsp_data_d = old_val;
          if (op_q == OpLr) begin
            rsv_vld_d[tid_q]  = 1'b1;
            rsv_gran_d[tid_q] = cur_gran;
            state_d           = StResp;
          end else begin
            wr_data_d = wr_val;
            state_d   = StWr;
          end
        end
      end
      StWr: begin
        if (mem_wr_ready) state_d = StResp;
      end
      StResp: begin
        if ((op_q == OpSc) && !rsp_err_q) rsv_vld_d[tid_q] = 1'b0;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // Applied after any LR set so a same-cycle kill or clear wins.
    for (int t = 0; t < NUM_THREADS; t++) begin
      if (rsv_clear[t] ||
          (snoop_valid && (rsv_gran_d[t] == snoop_gran)) ||
          (wr_fire && (rsv_gran_d[t] == cur_gran))) begin
        rsv_vld_d[t] = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      tid_q      <= '0;
      op_q       <= '0;
      dw_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      wr_data_q  <= '0;
      rsp_data_q <= '0;
      rsp_err_q  <= 1'b0;
      rsv_vld_q  <= '0;
      rsv_gran_q <= '{default: '0};
    end else begin
      state_q    <= state_d;
      tid_q      <= tid_d;
      op_q       <= op_d;
      dw_q       <= dw_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      wr_data_q  <= wr_data_d;
      rsp_data_q <= rsp_data_d;
      rsp_err_q  <= rsp_err_d;
      rsv_vld_q  <= rsv_vld_d;
      rsv_gran_q <= rsv_gran_d;
    end
  end

  assign req_ready    = (state_q == StIdle);
  assign mem_rd_valid = (state_q == StRd);
  assign mem_wr_valid = (state_q == StWr);
  assign mem_addr     = addr_q;
  assign mem_dw       = dw_q;
  assign mem_wdata    = wr_data_q;
  assign rsp_valid    = (state_q == StResp);
  assign rsp_tid      = tid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;

endmodule

// File: tb/tb_eh2_lsu_amo_seq.sv
// Bench for eh2_lsu_amo_seq (XLEN=64, 2 threads, 8-byte granule): directed cases then random ops
// against a word-addressed memory and an op-level reservation model.
module tb_eh2_lsu_amo_seq;

  localparam int unsigned XLEN = 64;
  localparam int unsigned NT   = 2;

  localparam logic [4:0] ADD = 5'd0, SWAP = 5'd1, LR = 5'd2, SC = 5'd3, XOR = 5'd4;
  localparam logic [4:0] OR = 5'd8, AND = 5'd12, MIN = 5'd16, MAX = 5'd20;
  localparam logic [4:0] MINU = 5'd24, MAXU = 5'd28, BADOP = 5'd7;

  logic            clk = 1'b0;
  logic            rst;
  logic            req_valid, req_ready;
  logic [0:0]      req_tid;
  logic [4:0]      req_op;
  logic            req_dw;
  logic [31:0]     req_addr;
  logic [63:0]     req_wdata;
  logic            mem_rd_valid, mem_rd_ready, mem_rdata_vld;
  logic [63:0]     mem_rdata;
  logic            mem_wr_valid, mem_wr_ready;
  logic [31:0]     mem_addr;
  logic            mem_dw;
  logic [63:0]     mem_wdata;
  logic            rsp_valid;
  logic [0:0]      rsp_tid;
  logic [63:0]     rsp_data;
  logic            rsp_err;
  logic            snoop_valid;
  logic [31:0]     snoop_addr;
  logic [NT-1:0]   rsv_clear;

  // Snoops come either from the main sequence (idle) or the responder (on data return).
  logic        snoop_main, snoop_ret, ret_snoop_en;
  logic [31:0] snoop_main_addr, ret_snoop_addr;
  assign snoop_valid = snoop_main | snoop_ret;
  assign snoop_addr  = snoop_ret ? ret_snoop_addr : snoop_main_addr;

  eh2_lsu_amo_seq #(.XLEN(XLEN), .NUM_THREADS(NT), .RSV_GRAN_LOG2(3)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_ready(req_ready), .req_tid(req_tid), .req_op(req_op),
    .req_dw(req_dw), .req_addr(req_addr), .req_wdata(req_wdata),
    .mem_rd_valid(mem_rd_valid), .mem_rd_ready(mem_rd_ready), .mem_rdata_vld(mem_rdata_vld),
    .mem_rdata(mem_rdata), .mem_wr_valid(mem_wr_valid), .mem_wr_ready(mem_wr_ready),
    .mem_addr(mem_addr), .mem_dw(mem_dw), .mem_wdata(mem_wdata),
    .rsp_valid(rsp_valid), .rsp_tid(rsp_tid), .rsp_data(rsp_data), .rsp_err(rsp_err),
    .snoop_valid(snoop_valid), .snoop_addr(snoop_addr), .rsv_clear(rsv_clear)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [31:0] addr; logic dw; logic [63:0] data;} wr_t;

  logic [31:0] mem [int unsigned];
  wr_t         wlog[$];
  int          rd_cnt = 0;
  logic [31:0] rd_addr_last;
  bit          fast = 1'b0;
  bit          hold_data = 1'b0;

  int errors = 0;
  int checks = 0;

  // Reference reservation state, one entry per thread.
  bit          m_vld [NT];
  logic [28:0] m_gran[NT];

  logic [63:0] last_rsp;
  logic [63:0] last_wd;
  int          last_wr, last_lat, last_rd;
  logic        last_err;

  function automatic logic [31:0] rd32(logic [31:0] a);
    return mem.exists(a >> 2) ? mem[a >> 2] : 32'h0;
  endfunction

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] amo_ref(logic [4:0] op, logic dw, logic [63:0] m,
                                          logic [63:0] s);
    longint          sm, ss;
    longint unsigned um, us, r;
    if (dw) begin
      um = m; us = s; sm = m; ss = s;
    end else begin
      um = {32'h0, m[31:0]};
      us = {32'h0, s[31:0]};
      sm = {{32{m[31]}}, m[31:0]};
      ss = {{32{s[31]}}, s[31:0]};
    end
    case (op)
      ADD:     r = um + us;
      SWAP:    r = us;
      XOR:     r = um ^ us;
      OR:      r = um | us;
      AND:     r = um & us;
      MIN:     r = (ss < sm) ? us : um;
      MAX:     r = (ss > sm) ? us : um;
      MINU:    r = (us < um) ? us : um;
      default: r = (us > um) ? us : um;
    endcase
    return dw ? r : {32'h0, r[31:0]};
  endfunction

  // Memory responder: random back-pressure and 0-2 cycle read latency unless fast.
  initial begin : responder
    bit          pend = 1'b0;
    int          wait_n = 0;
    logic [31:0] ra;
    logic        rdw;
    mem_rd_ready = 1'b0; mem_wr_ready = 1'b0; mem_rdata_vld = 1'b0; mem_rdata = '0;
    snoop_ret = 1'b0;
    forever begin
      @(negedge clk);
      if (mem_rd_valid && mem_rd_ready) begin
        pend = 1'b1; ra = mem_addr; rdw = mem_dw; rd_cnt++; rd_addr_last = mem_addr;
        wait_n = fast ? 0 : $urandom_range(0, 2);
      end
      if (mem_wr_valid && mem_wr_ready) begin
        wlog.push_back('{addr: mem_addr, dw: mem_dw, data: mem_wdata});
        mem[mem_addr >> 2] = mem_wdata[31:0];
        if (mem_dw) mem[(mem_addr >> 2) + 1] = mem_wdata[63:32];
      end
      @(posedge clk);
      #1;
      mem_rdata_vld = 1'b0;
      snoop_ret     = 1'b0;
      if (rst) pend = 1'b0;
      if (pend && !hold_data) begin
        if (wait_n == 0) begin
          mem_rdata_vld = 1'b1;
          mem_rdata = rdw ? {rd32(ra + 4), rd32(ra)} : {$urandom(), rd32(ra)};
          snoop_ret = ret_snoop_en;
          pend = 1'b0;
        end else begin
          wait_n--;
        end
      end
      mem_rd_ready = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
      mem_wr_ready = fast ? 1'b1 : ($urandom_range(0, 3) != 0);
    end
  end

  // Issue one op, check the response and memory traffic, then advance the model.
  task automatic do_op(input int tid, input logic [4:0] op, input logic dw,
                       input logic [31:0] addr, input logic [63:0] wd);
    logic [63:0] old, exp_rsp, exp_wd;
    logic [28:0] gran;
    bit          exp_err, exp_wr, exp_rd, got;
    int          rd0, n;
    exp_err = !(op inside {ADD, SWAP, LR, SC, XOR, OR, AND, MIN, MAX, MINU, MAXU}) ||
              (dw ? (addr[2:0] != 3'b0) : (addr[1:0] != 2'b0));
    old  = dw ? {rd32(addr + 4), rd32(addr)} : {32'h0, rd32(addr)};
    gran = addr[31:3];
    exp_rd = 1'b0; exp_wr = 1'b0; exp_wd = '0; exp_rsp = '0;
    if (exp_err) begin
      exp_rsp = '0;
    end else if (op == SC) begin
      exp_wr  = m_vld[tid] && (m_gran[tid] == gran);
      exp_rsp = exp_wr ? 64'd0 : 64'd1;
      exp_wd  = dw ? wd : {32'h0, wd[31:0]};
    end else begin
      exp_rd  = 1'b1;
      exp_wr  = (op != LR);
      exp_rsp = dw ? old : {{32{old[31]}}, old[31:0]};
      exp_wd  = amo_ref(op, dw, old, wd);
    end
    wlog.delete();
    rd0 = rd_cnt;
    n = 0;
    while (!req_ready && n < 100) begin @(negedge clk); n++; end
    chk("req_ready_before_issue", req_ready, 1'b1);
    req_valid = 1'b1; req_tid = tid[0]; req_op = op; req_dw = dw; req_addr = addr; req_wdata = wd;
    @(posedge clk);
    #1 req_valid = 1'b0;
    got = 1'b0; last_lat = 0;
    while (last_lat < 300 && !got) begin
      @(negedge clk);
      last_lat++;
      if (rsp_valid) got = 1'b1;
    end
    chk("rsp_seen", got, 1'b1);
    chk("rsp_err", rsp_err, exp_err);
    chk("rsp_data", rsp_data, exp_rsp);
    chk("rsp_tid", rsp_tid, tid[0]);
    last_rsp = rsp_data; last_err = rsp_err;
    @(negedge clk);
    chk("rsp_one_cycle", {rsp_valid, req_ready}, 2'b01);
    last_rd = rd_cnt - rd0;
    chk("read_count", last_rd, exp_rd);
    if (exp_rd && last_rd == 1) chk("read_addr", rd_addr_last, addr);
    last_wr = wlog.size();
    chk("write_count", last_wr, exp_wr);
    last_wd = '0;
    if (exp_wr && last_wr == 1) begin
      last_wd = wlog[0].data;
      chk("write_addr", wlog[0].addr, addr);
      chk("write_dw", wlog[0].dw, dw);
      chk("write_data", wlog[0].data, exp_wd);
    end
    if (!exp_err) begin
      if (op == LR) begin
        m_vld[tid]  = !(ret_snoop_en && ret_snoop_addr[31:3] == gran);
        m_gran[tid] = gran;
        for (int t = 0; t < NT; t++)
          if (t != tid && ret_snoop_en && m_gran[t] == ret_snoop_addr[31:3]) m_vld[t] = 1'b0;
      end
      if (exp_wr) for (int t = 0; t < NT; t++) if (m_gran[t] == gran) m_vld[t] = 1'b0;
      if (op == SC) m_vld[tid] = 1'b0;
    end
  endtask

  task automatic idle_snoop(input logic [31:0] a);
    snoop_main = 1'b1; snoop_main_addr = a;
    @(negedge clk);
    snoop_main = 1'b0;
    for (int t = 0; t < NT; t++) if (m_gran[t] == a[31:3]) m_vld[t] = 1'b0;
  endtask

  task automatic idle_clear(input logic [NT-1:0] c);
    rsv_clear = c;
    @(negedge clk);
    rsv_clear = '0;
    for (int t = 0; t < NT; t++) if (c[t]) m_vld[t] = 1'b0;
  endtask

  initial begin : main
    int          n;
    bit          seen;
    logic [4:0]  ops [12];
    logic [31:0] a;
    logic        dw;
    ops = '{ADD, SWAP, LR, SC, XOR, OR, AND, MIN, MAX, MINU, MAXU, BADOP};
    rst = 1'b1; req_valid = 1'b0; req_tid = '0; req_op = '0; req_dw = 1'b0; req_addr = '0;
    req_wdata = '0; snoop_main = 1'b0; snoop_main_addr = '0; ret_snoop_en = 1'b0;
    ret_snoop_addr = '0; rsv_clear = '0;
    for (int t = 0; t < NT; t++) begin m_vld[t] = 1'b0; m_gran[t] = '0; end
    repeat (3) @(negedge clk);
    chk("reset_outputs", {req_ready, mem_rd_valid, mem_wr_valid, rsp_valid, rsp_err, mem_dw},
        6'b100000);
    chk("reset_data", mem_addr | mem_wdata | rsp_data, 64'h0);
    rst = 1'b0;
    @(negedge clk);

    // amoadd.w wrap, minimum latency
    fast = 1'b1;
    mem[32'h40 >> 2] = 32'hFFFF_FFFF;
    do_op(0, ADD, 1'b0, 32'h40, 64'h1);
    chk("add_wrap_wd", last_wd, 64'h0);
    chk("add_wrap_rsp", last_rsp, 64'hFFFF_FFFF_FFFF_FFFF);
    chk("latency", last_lat, 4);
    fast = 1'b0;

    mem[32'h48 >> 2] = 32'h8000_0000;
    do_op(1, MIN, 1'b0, 32'h48, 64'h1);
    chk("min_wd", last_wd, 64'h8000_0000);
    mem[32'h48 >> 2] = 32'h8000_0000;
    do_op(1, MINU, 1'b0, 32'h48, 64'h1);
    chk("minu_wd", last_wd, 64'h1);

    mem[32'h50 >> 2] = 32'h7FFF_FFFF;
    do_op(0, MAX, 1'b0, 32'h50, 64'hFFFF_FFFF);
    chk("max_wd", last_wd, 64'h7FFF_FFFF);
    chk("max_rsp", last_rsp, 64'h7FFF_FFFF);

    mem[32'h58 >> 2] = 32'hFFFF_FFFF; mem[32'h5C >> 2] = 32'h1;
    do_op(1, ADD, 1'b1, 32'h58, 64'h1);
    chk("add_d_wd", last_wd, 64'h2_0000_0000);

    // LR reservation killed by another thread's AMO; SC retry still fails
    do_op(0, LR, 1'b0, 32'h100, 64'h0);
    do_op(1, SWAP, 1'b0, 32'h100, 64'h1234);
    do_op(0, SC, 1'b0, 32'h100, 64'h55);
    chk("sc_after_swap", {last_rsp, 32'(last_wr)}, {64'd1, 32'd0});
    do_op(0, SC, 1'b0, 32'h100, 64'h55);
    chk("sc_retry", last_rsp, 64'd1);

    // Snoop in the LR data-return cycle beats the reservation set
    ret_snoop_en = 1'b1; ret_snoop_addr = 32'h200;
    do_op(0, LR, 1'b0, 32'h200, 64'h0);
    ret_snoop_en = 1'b0;
    do_op(0, SC, 1'b0, 32'h200, 64'h66);
    chk("sc_after_snoop", last_rsp, 64'd1);
    do_op(0, LR, 1'b0, 32'h200, 64'h0);
    do_op(0, SC, 1'b0, 32'h200, 64'h66);
    chk("sc_ok", {last_rsp, 32'(last_wr), last_wd}, {64'd0, 32'd1, 64'h66});

    // Errors: no memory access
    do_op(0, OR, 1'b0, 32'h102, 64'h1);
    chk("err_misaligned", {last_err, 32'(last_rd), last_rsp}, {1'b1, 32'd0, 64'd0});
    do_op(1, OR, 1'b1, 32'h104, 64'h1);
    chk("err_dw_misaligned", last_err, 1'b1);
    do_op(1, BADOP, 1'b0, 32'h104, 64'h1);
    chk("err_badop", last_err, 1'b1);

    // Reset while waiting for read data
    do_op(0, LR, 1'b0, 32'h300, 64'h0);
    hold_data = 1'b1;
    n = rd_cnt;
    req_valid = 1'b1; req_tid = 1'b1; req_op = OR; req_dw = 1'b0; req_addr = 32'h308;
    req_wdata = 64'hF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 50 && !seen; i++) begin @(negedge clk); seen = (rd_cnt != n); end
    chk("rst_read_issued", seen, 1'b1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("rst_mid_outputs", {req_ready, mem_rd_valid, mem_wr_valid, rsp_valid, rsp_err, mem_dw},
        6'b100000);
    chk("rst_mid_data", mem_addr | mem_wdata | rsp_data, 64'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0; hold_data = 1'b0;
    for (int t = 0; t < NT; t++) m_vld[t] = 1'b0;
    seen = 1'b0;
    repeat (6) begin @(negedge clk); if (rsp_valid || mem_rd_valid || mem_wr_valid) seen = 1'b1; end
    chk("rst_no_activity", seen, 1'b0);
    do_op(0, SC, 1'b0, 32'h300, 64'h5);
    chk("rst_drops_rsv", last_rsp, 64'd1);

    // Random mix against the model
    for (int i = 0; i < 150; i++) begin
      fast = ($urandom_range(0, 3) == 0);
      dw = $urandom_range(0, 1);
      a = 32'h400 + 32'($urandom_range(0, 3)) * 8 + (dw ? 32'h0 : 32'($urandom_range(0, 1)) * 4);
      if ($urandom_range(0, 15) == 0) a = a + 32'h2;
      if ($urandom_range(0, 5) == 0) idle_snoop(32'h400 + 32'($urandom_range(0, 3)) * 8);
      if ($urandom_range(0, 7) == 0) idle_clear(NT'($urandom_range(1, 3)));
      do_op($urandom_range(0, 1),
            ($urandom_range(0, 2) == 0) ? (($urandom_range(0, 1) == 0) ? LR : SC)
                                        : ops[$urandom_range(0, 11)],
            dw, a, {$urandom(), $urandom()});
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
